// File: rtl/aes_pkg.sv
// Shared AES types and constants for the AddRoundKey stage and its skid buffer.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int PARITY_W      = 16;

    typedef logic [127:0] aes_block_t;
    typedef logic [3:0]   aes_round_t;

    typedef enum logic [1:0] {
        ARK_EMPTY = 2'd0,
        ARK_ONE   = 2'd1,
        ARK_TWO   = 2'd2
    } ark_state_t;

    // Even parity per byte: bit i is the XOR of bits [8i+7:8i].
    function automatic logic [PARITY_W-1:0] byte_parity(input aes_block_t data);
        logic [PARITY_W-1:0] par;
        par = '0;
        for (int i = 0; i < PARITY_W; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/add_round_key_stage_if.sv
// Stream bundle for the AddRoundKey stage: upstream beat side and downstream
// result side. The slave modport is the stage; master is its environment.
// With ARK_PARITY_EN defined, the result side also carries per-byte parity.
interface add_round_key_stage_if #(
    parameter int ROUND_W = 4
);
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    aes_block_t         mix_packet;
    aes_block_t         shift_packet;
    aes_block_t         round_key;
    logic               out_valid;
    logic               out_ready;
    aes_block_t         out_packet;
    logic [ROUND_W-1:0] out_round;
    logic               out_last;
`ifdef ARK_PARITY_EN
    logic [PARITY_W-1:0] out_parity;
`endif

    modport slave (
        input  in_valid, mix_packet, shift_packet, round_key, out_ready,
`ifdef ARK_PARITY_EN
        output out_parity,
`endif
        output in_ready, out_valid, out_packet, out_round, out_last
    );

    modport master (
        output in_valid, mix_packet, shift_packet, round_key, out_ready,
`ifdef ARK_PARITY_EN
        input  out_parity,
`endif
        input  in_ready, out_valid, out_packet, out_round, out_last
    );

endinterface

// File: rtl/ark_skid_buffer.sv
// Two-entry register pair (output register + skid) with a valid/ready FSM.
// in_ready and out_valid are flops decoded from the next state, so there is
// no combinational path from out_ready to in_ready.
module ark_skid_buffer
    import aes_pkg::*;
#(
    parameter int W = 133
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam logic [1:0] ST_EMPTY = ARK_EMPTY;
    localparam logic [1:0] ST_ONE   = ARK_ONE;
    localparam logic [1:0] ST_TWO   = ARK_TWO;

    logic [1:0]   state_r;
    logic [1:0]   state_s;
    logic         out_valid_r;
    logic         in_ready_r;
    logic [W-1:0] out_data_r;
    logic [W-1:0] skid_data_r;
    logic         accept_s;
    logic         emit_s;
    logic         load_out_in_s;
    logic         load_out_skid_s;
    logic         load_skid_s;

    assign accept_s  = in_valid & in_ready_r;
    assign emit_s    = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Next-state and entry-load decode; clear drops everything in flight.
    always_comb begin
        state_s         = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (clear) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s       = ST_ONE;
                        load_out_in_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        state_s       = ST_ONE;
                        load_out_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_s     = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (emit_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        state_s         = ST_ONE;
                        load_out_skid_s = 1'b1;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State and handshake flags, both decoded from the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= (state_s != ST_TWO);
        end
    end

    // Payload registers; contents are kept across clear, only flags drop.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_data_r  <= '0;
            skid_data_r <= '0;
        end else begin
            if (load_out_in_s) begin
                out_data_r <= in_data;
            end else if (load_out_skid_s) begin
                out_data_r <= skid_data_r;
            end
            if (load_skid_s) begin
                skid_data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage: XORs the round state with the round key, selecting
// the ShiftRows state on the final round, tags each beat with its round index
// and registers it behind a 2-entry skid buffer.
// Optional feature macro: ARK_PARITY_EN adds 16-bit per-byte even parity.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int ROUND_W    = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    add_round_key_stage_if.slave  bus
);

    localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] FIRST_RND = ROUND_W'(1);
`ifdef ARK_PARITY_EN
    localparam int PAY_W = AES_BLOCK_W + ROUND_W + 1 + PARITY_W;
`else
    localparam int PAY_W = AES_BLOCK_W + ROUND_W + 1;
`endif

    logic [ROUND_W-1:0] rnd_r;
    logic               last_rnd_s;
    logic               in_ready_s;
    logic               accept_s;
    aes_block_t         state_sel_s;
    aes_block_t         key_xor_s;
    logic [PAY_W-1:0]   in_pay_s;
    logic [PAY_W-1:0]   out_pay_s;

    assign last_rnd_s = (rnd_r == LAST_RND);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign key_xor_s  = state_sel_s ^ bus.round_key;

    // Final round skips MixColumns, so take the ShiftRows state there.
    always_comb begin
        state_sel_s = bus.mix_packet;
        if (last_rnd_s) begin
            state_sel_s = bus.shift_packet;
        end else begin
            state_sel_s = bus.mix_packet;
        end
    end

    // Round counter: advances per accepted beat, wraps last round to round 1.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rnd_r <= FIRST_RND;
        end else if (clear) begin
            rnd_r <= FIRST_RND;
        end else if (accept_s) begin
            if (last_rnd_s) begin
                rnd_r <= FIRST_RND;
            end else begin
                rnd_r <= rnd_r + FIRST_RND;
            end
        end
    end

`ifdef ARK_PARITY_EN
    assign in_pay_s = {byte_parity(key_xor_s), last_rnd_s, rnd_r, key_xor_s};
    assign bus.out_parity = out_pay_s[PAY_W-1 -: PARITY_W];
`else
    assign in_pay_s = {last_rnd_s, rnd_r, key_xor_s};
`endif

    assign bus.in_ready   = in_ready_s;
    assign bus.out_packet = out_pay_s[AES_BLOCK_W-1:0];
    assign bus.out_round  = out_pay_s[AES_BLOCK_W +: ROUND_W];
    assign bus.out_last   = out_pay_s[AES_BLOCK_W + ROUND_W];

    ark_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_pay_s),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pay_s)
    );

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage: reset, round sequencing, back-
// pressure, concurrent accept/emit, clear and reset mid-block, and parity
// when ARK_PARITY_EN is defined.
module tb_add_round_key_stage;
    import aes_pkg::*;

    logic clk;
    logic n_rst;
    logic clear;
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    add_round_key_stage_if #(.ROUND_W(4)) bus ();

    add_round_key_stage #(
        .NUM_ROUNDS (10),
        .ROUND_W    (4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input aes_block_t mix, input aes_block_t shift, input aes_block_t key);
        bus.in_valid     = v;
        bus.mix_packet   = mix;
        bus.shift_packet = shift;
        bus.round_key    = key;
    endtask

    task automatic check_out(input string tag, input aes_block_t pkt, input logic [3:0] rnd, input logic last);
        check_value({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
        check_value({tag, "_packet"}, bus.out_packet, pkt);
        check_value({tag, "_round"}, 128'(bus.out_round), 128'(rnd));
        check_value({tag, "_last"}, 128'(bus.out_last), 128'(last));
    endtask

    task automatic check_reset(input string tag);
        check_value({tag, "_valid"}, 128'(bus.out_valid), 128'd0);
        check_value({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
        check_value({tag, "_packet"}, bus.out_packet, 128'd0);
        check_value({tag, "_round"}, 128'(bus.out_round), 128'd0);
        check_value({tag, "_last"}, 128'(bus.out_last), 128'd0);
`ifdef ARK_PARITY_EN
        check_value({tag, "_parity"}, 128'(bus.out_parity), 128'd0);
`endif
    endtask

    initial begin
        logic [7:0] b;
        n_rst = 1'b0;
        clear = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        check_reset("reset");

        // Beat 1 of a block, then rounds 2..10 back-to-back, then wrap.
        n_rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, {16{8'hFF}}, {16{8'hEE}}, {16{8'h0F}});
        step();
        check_out("t1", {16{8'hF0}}, 4'd1, 1'b0);
        check_value("t1_in_ready", 128'(bus.in_ready), 128'd1);
        for (int k = 2; k <= 9; k++) begin
            b = 8'(k);
            drive(1'b1, {16{b}}, {16{8'hEE}}, {16{8'h11}});
            step();
            check_out("t2_mid", {16{b ^ 8'h11}}, 4'(k), 1'b0);
        end
        drive(1'b1, {16{8'h55}}, {16{8'hAA}}, 128'd0);
        step();
        check_out("t2_last", {16{8'hAA}}, 4'd10, 1'b1);
        drive(1'b1, {16{8'h3C}}, {16{8'h99}}, {16{8'hC3}});
        step();
        check_out("t2_wrap", {16{8'hFF}}, 4'd1, 1'b0);
        drive(1'b0, '0, '0, '0);
        step();
        check_value("t2_drain", 128'(bus.out_valid), 128'd0);

        // Backpressure: fill both entries, then drain in order.
        bus.out_ready = 1'b0;
        drive(1'b1, {16{8'h12}}, '0, {16{8'h01}});
        step();
        check_out("t3_a", {16{8'h13}}, 4'd2, 1'b0);
        check_value("t3_rdy1", 128'(bus.in_ready), 128'd1);
        drive(1'b1, {16{8'h34}}, '0, {16{8'h01}});
        step();
        check_value("t3_full", 128'(bus.in_ready), 128'd0);
        check_out("t3_hold", {16{8'h13}}, 4'd2, 1'b0);
        drive(1'b1, {16{8'h56}}, '0, {16{8'h01}});
        step();
        check_value("t3_full2", 128'(bus.in_ready), 128'd0);
        check_out("t3_hold2", {16{8'h13}}, 4'd2, 1'b0);
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        step();
        check_out("t3_b", {16{8'h35}}, 4'd3, 1'b0);
        check_value("t3_rdy2", 128'(bus.in_ready), 128'd1);
        step();
        check_value("t3_empty", 128'(bus.out_valid), 128'd0);

        // Accept and emit at the same edge in ONE.
        drive(1'b1, {16{8'h40}}, '0, {16{8'h04}});
        step();
        check_out("t4_d", {16{8'h44}}, 4'd4, 1'b0);
        drive(1'b1, {16{8'h50}}, '0, {16{8'h05}});
        step();
        check_out("t4_e", {16{8'h55}}, 4'd5, 1'b0);
        drive(1'b0, '0, '0, '0);
        step();
        check_value("t4_nodup", 128'(bus.out_valid), 128'd0);

        // Clear mid-block in TWO, then clear with a same-cycle accept.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_value("t5_clr0_valid", 128'(bus.out_valid), 128'd0);
        drive(1'b1, {16{8'hA1}}, '0, '0);
        step();
        drive(1'b1, {16{8'hA2}}, '0, '0);
        step();
        drive(1'b1, {16{8'hA3}}, '0, '0);
        step();
        check_out("t5_r3", {16{8'hA3}}, 4'd3, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b1, {16{8'hA4}}, '0, '0);
        step();
        check_value("t5_two", 128'(bus.in_ready), 128'd0);
        clear = 1'b1;
        drive(1'b1, {16{8'hB0}}, '0, '0);
        step();
        clear = 1'b0;
        check_value("t5_clr_valid", 128'(bus.out_valid), 128'd0);
        check_value("t5_clr_ready", 128'(bus.in_ready), 128'd1);
        check_value("t5_clr_pkt", bus.out_packet, {16{8'hA3}});
        check_value("t5_clr_round", 128'(bus.out_round), 128'd3);
        bus.out_ready = 1'b1;
        drive(1'b1, {16{8'hB1}}, '0, '0);
        step();
        check_out("t5_restart", {16{8'hB1}}, 4'd1, 1'b0);
        clear = 1'b1;
        drive(1'b1, {16{8'hC1}}, '0, '0);
        step();
        clear = 1'b0;
        check_value("t5_drop_valid", 128'(bus.out_valid), 128'd0);
        check_value("t5_drop_pkt", bus.out_packet, {16{8'hB1}});
        drive(1'b1, {16{8'hD1}}, '0, '0);
        step();
        check_out("t5_after_drop", {16{8'hD1}}, 4'd1, 1'b0);

        // Reset mid-block with both entries full.
        bus.out_ready = 1'b0;
        drive(1'b1, {16{8'hE2}}, '0, '0);
        step();
        drive(1'b1, {16{8'hE3}}, '0, '0);
        step();
        check_value("t5_two_b", 128'(bus.in_ready), 128'd0);
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        check_reset("t5_rst");
        bus.out_ready = 1'b1;
        drive(1'b1, {16{8'hF1}}, '0, '0);
        step();
        check_out("t5_rst_first", {16{8'hF1}}, 4'd1, 1'b0);

`ifdef ARK_PARITY_EN
        drive(1'b1, {16{8'h01}}, '0, '0);
        step();
        check_value("t6_par_ff", 128'(bus.out_parity), 128'h0000_FFFF);
        drive(1'b1, {16{8'h03}}, '0, '0);
        step();
        check_value("t6_par_00", 128'(bus.out_parity), 128'd0);
`endif
        drive(1'b0, '0, '0, '0);
        step();
        check_value("end_empty", 128'(bus.out_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
